mem_dp_sync: RTL and testbench

- Dual-port, byte-addressed, byte-strobed SRAM model with registered reads.
- Successor to the single-port async-read memory.
- Two independent request ports (A, B) with valid/ready handshake, configurable read latency, defined read-during-write and write-write collision behaviour.
- Backs instruction/data buses in the SoC, or a DMA plus CPU pair sharing one memory.

---
 rtl/mem_pkg.sv | 11 +
 rtl/mem_rsp_pipe.sv | 35 +++
 rtl/mem_dp_sync.sv | 123 ++++++++++++
 tb/tb_mem_dp_sync.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and limits for the dual-port synchronous memory.
package mem_pkg;

  typedef enum logic {
    RDW_READ_FIRST,
    RDW_WRITE_FIRST
  } rdw_mode_e;

  localparam int MAX_READ_LATENCY = 3;

endpackage

// File: rtl/mem_rsp_pipe.sv
// Fixed-latency response pipeline: carries {valid, data} through READ_LATENCY
// register stages; reset flushes every stage so no stale response survives.
module mem_rsp_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic [READ_LATENCY-1:0] vld_q;
  logic [DATA_WIDTH-1:0]   dat_q [READ_LATENCY];

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      vld_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= in_valid;
      dat_q[0] <= in_data;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[READ_LATENCY-1];
  assign out_data  = dat_q[READ_LATENCY-1];

endmodule

// File: rtl/mem_dp_sync.sv
// Dual-port byte-strobed SRAM with registered reads, write/write collision
// arbitration (port A wins) and selectable cross-port read-during-write result.
module mem_dp_sync
  import mem_pkg::*;
#(
  parameter int        ADDR_WIDTH   = 10,
  parameter int        DATA_WIDTH   = 32,
  parameter int        READ_LATENCY = 1,
  parameter rdw_mode_e RDW_MODE     = RDW_READ_FIRST
) (
  input  logic                    clk_i,
  input  logic                    arst_i,
  input  logic                    a_req_valid_i,
  output logic                    a_req_ready_o,
  input  logic [ADDR_WIDTH-1:0]   a_addr_i,
  input  logic                    a_we_i,
  input  logic [DATA_WIDTH-1:0]   a_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] a_wstrb_i,
  output logic                    a_rvalid_o,
  output logic [DATA_WIDTH-1:0]   a_rdata_o,
  input  logic                    b_req_valid_i,
  output logic                    b_req_ready_o,
  input  logic [ADDR_WIDTH-1:0]   b_addr_i,
  input  logic                    b_we_i,
  input  logic [DATA_WIDTH-1:0]   b_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] b_wstrb_i,
  output logic                    b_rvalid_o,
  output logic [DATA_WIDTH-1:0]   b_rdata_o
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF    = $clog2(STRB_W);
  localparam int ROW_W  = ADDR_WIDTH - OFF;
  localparam int ROWS   = 1 << ROW_W;

  if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
    $error("mem_dp_sync: READ_LATENCY %0d outside 1..%0d", READ_LATENCY, MAX_READ_LATENCY);
  end
  if (DATA_WIDTH < 8 || (DATA_WIDTH & (DATA_WIDTH - 1)) != 0) begin : g_bad_width
    $error("mem_dp_sync: DATA_WIDTH %0d must be a power of two >= 8", DATA_WIDTH);
  end

  // Sub-row address bits only select a byte lane; rows alias across them.
  if (OFF > 0) begin : g_unused_off
    logic unused_low_bits;
    assign unused_low_bits = ^{a_addr_i[OFF-1:0], b_addr_i[OFF-1:0]};
  end

  logic [DATA_WIDTH-1:0] mem_q [ROWS];

  logic [ROW_W-1:0]      row_a, row_b;
  logic                  same_row, acc_a, acc_b;
  logic [DATA_WIDTH-1:0] a_rd, b_rd, a_pipe_data, b_pipe_data;

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_row,
    input logic [DATA_WIDTH-1:0] wdata,
    input logic [STRB_W-1:0]     wstrb
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_row;
    for (int i = 0; i < STRB_W; i++) begin
      if (wstrb[i]) res[i*8 +: 8] = wdata[i*8 +: 8];
    end
    return res;
  endfunction

  assign row_a    = a_addr_i[ADDR_WIDTH-1:OFF];
  assign row_b    = b_addr_i[ADDR_WIDTH-1:OFF];
  assign same_row = (row_a == row_b);

  // Handshake: a request transfers on a rising edge where valid && ready.
  // A requester must hold valid and payload stable until that edge. Ready is
  // low during reset; B's ready also drops for a same-row write/write clash,
  // so A's write lands first and B's held write overlays it a cycle later.
  assign a_req_ready_o = ~arst_i;
  assign b_req_ready_o = ~arst_i & ~(a_req_valid_i & a_we_i & b_we_i & same_row);

  assign acc_a = a_req_valid_i & a_req_ready_o;
  assign acc_b = b_req_valid_i & b_req_ready_o;

  // Array is deliberately not reset; contents survive arst_i.
  always_ff @(posedge clk_i) begin
    if (acc_a && a_we_i) mem_q[row_a] <= merge_bytes(mem_q[row_a], a_wdata_i, a_wstrb_i);
    if (acc_b && b_we_i) mem_q[row_b] <= merge_bytes(mem_q[row_b], b_wdata_i, b_wstrb_i);
  end

  always_comb begin
    a_rd = mem_q[row_a];
    b_rd = mem_q[row_b];
    if (RDW_MODE == RDW_WRITE_FIRST && same_row) begin
      if (acc_b && b_we_i) a_rd = merge_bytes(a_rd, b_wdata_i, b_wstrb_i);
      if (acc_a && a_we_i) b_rd = merge_bytes(b_rd, a_wdata_i, a_wstrb_i);
    end
    a_pipe_data = (acc_a && !a_we_i) ? a_rd : '0;
    b_pipe_data = (acc_b && !b_we_i) ? b_rd : '0;
  end

  mem_rsp_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_pipe_a (
    .clk_i    (clk_i),
    .arst_i   (arst_i),
    .in_valid (acc_a),
    .in_data  (a_pipe_data),
    .out_valid(a_rvalid_o),
    .out_data (a_rdata_o)
  );

  mem_rsp_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_pipe_b (
    .clk_i    (clk_i),
    .arst_i   (arst_i),
    .in_valid (acc_b),
    .in_data  (b_pipe_data),
    .out_valid(b_rvalid_o),
    .out_data (b_rdata_o)
  );

endmodule

// File: tb/tb_mem_dp_sync.sv
// Bench for mem_dp_sync: three instances share stimulus (read-first L1,
// write-first L1, read-first L3) and are checked against a row-array model.
module tb_mem_dp_sync;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        arst;
  logic        a_v, a_we, b_v, b_we;
  logic [5:0]  a_addr, b_addr;
  logic [31:0] a_wd, b_wd;
  logic [3:0]  a_st, b_st;

  // index 0 = read-first L1, 1 = write-first L1, 2 = read-first L3
  logic [2:0]       a_rdy, b_rdy, a_rv, b_rv;
  logic [2:0][31:0] a_rd, b_rd;

  int errors = 0;
  int checks = 0;

  logic [31:0] ref_mem [16];
  logic [65:0] exp_q [$];

  always #5 clk = ~clk;

  mem_dp_sync #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .READ_LATENCY(1), .RDW_MODE(RDW_READ_FIRST)) dut_rf (
    .clk_i(clk), .arst_i(arst),
    .a_req_valid_i(a_v), .a_req_ready_o(a_rdy[0]), .a_addr_i(a_addr), .a_we_i(a_we),
    .a_wdata_i(a_wd), .a_wstrb_i(a_st), .a_rvalid_o(a_rv[0]), .a_rdata_o(a_rd[0]),
    .b_req_valid_i(b_v), .b_req_ready_o(b_rdy[0]), .b_addr_i(b_addr), .b_we_i(b_we),
    .b_wdata_i(b_wd), .b_wstrb_i(b_st), .b_rvalid_o(b_rv[0]), .b_rdata_o(b_rd[0]));

  mem_dp_sync #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .READ_LATENCY(1), .RDW_MODE(RDW_WRITE_FIRST)) dut_wf (
    .clk_i(clk), .arst_i(arst),
    .a_req_valid_i(a_v), .a_req_ready_o(a_rdy[1]), .a_addr_i(a_addr), .a_we_i(a_we),
    .a_wdata_i(a_wd), .a_wstrb_i(a_st), .a_rvalid_o(a_rv[1]), .a_rdata_o(a_rd[1]),
    .b_req_valid_i(b_v), .b_req_ready_o(b_rdy[1]), .b_addr_i(b_addr), .b_we_i(b_we),
    .b_wdata_i(b_wd), .b_wstrb_i(b_st), .b_rvalid_o(b_rv[1]), .b_rdata_o(b_rd[1]));

  mem_dp_sync #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .READ_LATENCY(3), .RDW_MODE(RDW_READ_FIRST)) dut_l3 (
    .clk_i(clk), .arst_i(arst),
    .a_req_valid_i(a_v), .a_req_ready_o(a_rdy[2]), .a_addr_i(a_addr), .a_we_i(a_we),
    .a_wdata_i(a_wd), .a_wstrb_i(a_st), .a_rvalid_o(a_rv[2]), .a_rdata_o(a_rd[2]),
    .b_req_valid_i(b_v), .b_req_ready_o(b_rdy[2]), .b_addr_i(b_addr), .b_we_i(b_we),
    .b_wdata_i(b_wd), .b_wstrb_i(b_st), .b_rvalid_o(b_rv[2]), .b_rdata_o(b_rd[2]));

  function automatic logic [31:0] overlay(input logic [31:0] old_row, input logic [31:0] wd,
                                          input logic [3:0] st);
    logic [31:0] res;
    res = old_row;
    for (int i = 0; i < 4; i++) if (st[i]) res[i*8 +: 8] = wd[i*8 +: 8];
    return res;
  endfunction

  task automatic set_a(input logic v, input logic we, input logic [5:0] addr,
                       input logic [31:0] wd, input logic [3:0] st);
    a_v = v; a_we = we; a_addr = addr; a_wd = wd; a_st = st;
  endtask

  task automatic set_b(input logic v, input logic we, input logic [5:0] addr,
                       input logic [31:0] wd, input logic [3:0] st);
    b_v = v; b_we = we; b_addr = addr; b_wd = wd; b_st = st;
  endtask

  task automatic idle();
    set_a(1'b0, 1'b0, 6'h0, 32'h0, 4'h0);
    set_b(1'b0, 1'b0, 6'h0, 32'h0, 4'h0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({a_rdy[d], b_rdy[d], a_rv[d], b_rv[d]} !== 4'b0000) begin
        errors++; $display("FAIL reset_ctrl dut%0d: got %b want 0000", d, {a_rdy[d], b_rdy[d], a_rv[d], b_rv[d]});
      end
      checks++;
      if ({a_rd[d], b_rd[d]} !== 64'h0) begin
        errors++; $display("FAIL reset_rdata dut%0d: got %h want 0", d, {a_rd[d], b_rd[d]});
      end
    end
    arst = 1'b0;
    #1;
    checks++;
    if ({a_rdy[0], b_rdy[0]} !== 2'b11) begin
      errors++; $display("FAIL reset_release_ready: got %b want 11", {a_rdy[0], b_rdy[0]});
    end
  endtask

  task automatic test_basic();
    @(negedge clk); set_a(1'b1, 1'b1, 6'h04, 32'hDEADBEEF, 4'hF);
    @(posedge clk); #1;
    checks++;
    if (a_rv[0] !== 1'b1 || a_rd[0] !== 32'h0) begin
      errors++; $display("FAIL basic_wr_rsp: got v=%b d=%h want v=1 d=0", a_rv[0], a_rd[0]);
    end
    @(negedge clk); idle(); set_b(1'b0 | 1'b1, 1'b0, 6'h07, 32'h0, 4'h0);
    @(posedge clk); #1;
    checks++;
    if (a_rv[0] !== 1'b0) begin
      errors++; $display("FAIL basic_single_pulse: got %b want 0", a_rv[0]);
    end
    checks++;
    if (b_rv[0] !== 1'b1 || b_rd[0] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL basic_alias_read: got v=%b d=%h want v=1 d=deadbeef", b_rv[0], b_rd[0]);
    end
    @(negedge clk); idle();
    @(posedge clk); #1;
    checks++;
    if (b_rv[0] !== 1'b0 || b_rd[0] !== 32'h0) begin
      errors++; $display("FAIL basic_idle_zero: got v=%b d=%h want v=0 d=0", b_rv[0], b_rd[0]);
    end
  endtask

  task automatic test_partial();
    @(negedge clk); set_a(1'b1, 1'b1, 6'h04, 32'h000000A5, 4'h1);
    @(negedge clk); set_a(1'b1, 1'b0, 6'h04, 32'h0, 4'h0);
    @(posedge clk); #1;
    checks++;
    if (a_rd[0] !== 32'hDEADBEA5) begin
      errors++; $display("FAIL partial_strobe: got %h want deadbea5", a_rd[0]);
    end
    @(negedge clk); set_a(1'b1, 1'b1, 6'h04, 32'hFFFFFFFF, 4'h0);
    @(posedge clk); #1;
    checks++;
    if (a_rv[0] !== 1'b1 || a_rd[0] !== 32'h0) begin
      errors++; $display("FAIL zero_strobe_rsp: got v=%b d=%h want v=1 d=0", a_rv[0], a_rd[0]);
    end
    @(negedge clk); set_a(1'b1, 1'b0, 6'h05, 32'h0, 4'h0);
    @(posedge clk); #1;
    checks++;
    if (a_rd[0] !== 32'hDEADBEA5) begin
      errors++; $display("FAIL zero_strobe_keep: got %h want deadbea5", a_rd[0]);
    end
    @(negedge clk); idle();
  endtask

  task automatic test_reset_midflight();
    @(negedge clk); set_a(1'b1, 1'b0, 6'h04, 32'h0, 4'h0);
    @(posedge clk); #1;
    idle();
    checks++;
    if (a_rv[0] !== 1'b1 || a_rd[0] !== 32'hDEADBEA5) begin
      errors++; $display("FAIL midflight_pre: got v=%b d=%h want v=1 d=deadbea5", a_rv[0], a_rd[0]);
    end
    #2 arst = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({a_rv[d], a_rdy[d], a_rd[d]} !== 34'h0) begin
        errors++; $display("FAIL midflight_clear dut%0d: got v=%b r=%b d=%h want all 0", d, a_rv[d], a_rdy[d], a_rd[d]);
      end
    end
    @(negedge clk); @(negedge clk); arst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (a_rv !== 3'b000) begin
        errors++; $display("FAIL midflight_no_rsp cycle%0d: got %b want 000", c, a_rv);
      end
    end
    @(negedge clk); set_a(1'b1, 1'b0, 6'h04, 32'h0, 4'h0);
    @(posedge clk); #1;
    checks++;
    if (a_rv[0] !== 1'b1 || a_rd[0] !== 32'hDEADBEA5) begin
      errors++; $display("FAIL midflight_retain: got v=%b d=%h want v=1 d=deadbea5", a_rv[0], a_rd[0]);
    end
    @(negedge clk); idle();
  endtask

  task automatic test_collision();
    int na = 0;
    int nb = 0;
    @(negedge clk);
    set_a(1'b1, 1'b1, 6'h08, 32'h11111111, 4'hF);
    set_b(1'b1, 1'b1, 6'h0A, 32'h22222222, 4'hF);
    #1;
    checks++;
    if (a_rdy[0] !== 1'b1 || b_rdy[0] !== 1'b0) begin
      errors++; $display("FAIL collide_ready: got a=%b b=%b want a=1 b=0", a_rdy[0], b_rdy[0]);
    end
    @(posedge clk); #1;
    na += int'(a_rv[0]); nb += int'(b_rv[0]);
    @(negedge clk); set_a(1'b0, 1'b0, 6'h0, 32'h0, 4'h0);
    #1;
    checks++;
    if (b_rdy[0] !== 1'b1) begin
      errors++; $display("FAIL collide_retry_ready: got %b want 1", b_rdy[0]);
    end
    @(posedge clk); #1;
    na += int'(a_rv[0]); nb += int'(b_rv[0]);
    @(negedge clk); idle(); set_a(1'b1, 1'b0, 6'h08, 32'h0, 4'h0);
    @(posedge clk); #1;
    na += int'(a_rv[0]); nb += int'(b_rv[0]);
    checks++;
    if (a_rd[0] !== 32'h22222222) begin
      errors++; $display("FAIL collide_content: got %h want 22222222", a_rd[0]);
    end
    checks++;
    if (na != 2 || nb != 1) begin
      errors++; $display("FAIL collide_rsp_count: got a=%0d b=%0d want a=2 b=1", na, nb);
    end
    @(negedge clk); idle();
  endtask

  task automatic test_rdw();
    @(negedge clk); set_a(1'b1, 1'b1, 6'h0C, 32'h0, 4'hF);
    @(negedge clk);
    set_a(1'b1, 1'b1, 6'h0C, 32'hCAFEF00D, 4'hF);
    set_b(1'b1, 1'b0, 6'h0D, 32'h0, 4'h0);
    @(posedge clk); #1;
    checks++;
    if (b_rv[0] !== 1'b1 || b_rd[0] !== 32'h0) begin
      errors++; $display("FAIL rdw_read_first_b: got v=%b d=%h want v=1 d=0", b_rv[0], b_rd[0]);
    end
    checks++;
    if (b_rv[1] !== 1'b1 || b_rd[1] !== 32'hCAFEF00D) begin
      errors++; $display("FAIL rdw_write_first_b: got v=%b d=%h want v=1 d=cafef00d", b_rv[1], b_rd[1]);
    end
    @(negedge clk);
    set_a(1'b1, 1'b0, 6'h0C, 32'h0, 4'h0);
    set_b(1'b1, 1'b1, 6'h0E, 32'h12345678, 4'h3);
    @(posedge clk); #1;
    checks++;
    if (a_rd[0] !== 32'hCAFEF00D) begin
      errors++; $display("FAIL rdw_read_first_a: got %h want cafef00d", a_rd[0]);
    end
    checks++;
    if (a_rd[1] !== 32'hCAFE5678) begin
      errors++; $display("FAIL rdw_write_first_a: got %h want cafe5678", a_rd[1]);
    end
    @(negedge clk); idle();
  endtask

  task automatic test_latency();
    for (int r = 0; r < 4; r++) begin
      @(negedge clk); set_a(1'b1, 1'b1, 6'(r * 4), 32'(r), 4'hF);
    end
    @(negedge clk); idle();
    repeat (4) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      if (k < 4) set_a(1'b1, 1'b0, 6'(k * 4), 32'h0, 4'h0);
      else       idle();
      @(posedge clk); #1;
      checks++;
      if (a_rv[2] !== ((k >= 2 && k <= 5) ? 1'b1 : 1'b0) ||
          a_rd[2] !== ((k >= 2 && k <= 5) ? 32'(k - 2) : 32'h0)) begin
        errors++; $display("FAIL latency3 cycle%0d: got v=%b d=%h", k + 1, a_rv[2], a_rd[2]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic        hold, exp_brdy, acc_a, acc_b;
    logic [3:0]  ra, rb;
    logic [31:0] exp_a_rf, exp_b_rf, exp_a_wf, exp_b_wf;
    logic [65:0] e;
    hold = 1'b0;
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      ref_mem[r] = $urandom;
      set_a(1'b1, 1'b1, 6'(r * 4), ref_mem[r], 4'hF);
    end
    @(negedge clk); idle();
    repeat (4) @(negedge clk);
    exp_q.delete();
    exp_q.push_back(66'h0);
    exp_q.push_back(66'h0);
    for (int c = 0; c < 300; c++) begin
      set_a($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 15)),
            $urandom, 4'($urandom_range(0, 15)));
      if (!hold)
        set_b($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 15)),
              $urandom, 4'($urandom_range(0, 15)));
      #1;
      ra = a_addr[5:2];
      rb = b_addr[5:2];
      exp_brdy = !(a_v && a_we && b_we && ra == rb);
      checks++;
      if (a_rdy[0] !== 1'b1 || b_rdy[0] !== exp_brdy) begin
        errors++; $display("FAIL rand_ready c%0d: got a=%b b=%b want a=1 b=%b", c, a_rdy[0], b_rdy[0], exp_brdy);
      end
      acc_a = a_v;
      acc_b = b_v && exp_brdy;
      exp_a_rf = (acc_a && !a_we) ? ref_mem[ra] : 32'h0;
      exp_b_rf = (acc_b && !b_we) ? ref_mem[rb] : 32'h0;
      exp_a_wf = (acc_a && !a_we && acc_b && b_we && ra == rb) ? overlay(ref_mem[ra], b_wd, b_st) : exp_a_rf;
      exp_b_wf = (acc_b && !b_we && acc_a && a_we && ra == rb) ? overlay(ref_mem[rb], a_wd, a_st) : exp_b_rf;
      @(posedge clk); #1;
      if (acc_a && a_we) ref_mem[ra] = overlay(ref_mem[ra], a_wd, a_st);
      if (acc_b && b_we) ref_mem[rb] = overlay(ref_mem[rb], b_wd, b_st);
      hold = b_v && !exp_brdy;
      checks++;
      if ({a_rv[0], a_rd[0], b_rv[0], b_rd[0]} !== {acc_a, exp_a_rf, acc_b, exp_b_rf}) begin
        errors++; $display("FAIL rand_rf c%0d: got a=%b/%h b=%b/%h want a=%b/%h b=%b/%h", c,
                           a_rv[0], a_rd[0], b_rv[0], b_rd[0], acc_a, exp_a_rf, acc_b, exp_b_rf);
      end
      checks++;
      if ({a_rv[1], a_rd[1], b_rv[1], b_rd[1]} !== {acc_a, exp_a_wf, acc_b, exp_b_wf}) begin
        errors++; $display("FAIL rand_wf c%0d: got a=%b/%h b=%b/%h want a=%b/%h b=%b/%h", c,
                           a_rv[1], a_rd[1], b_rv[1], b_rd[1], acc_a, exp_a_wf, acc_b, exp_b_wf);
      end
      exp_q.push_back({acc_a, exp_a_rf, acc_b, exp_b_rf});
      e = exp_q.pop_front();
      checks++;
      if ({a_rv[2], a_rd[2], b_rv[2], b_rd[2]} !== e) begin
        errors++; $display("FAIL rand_l3 c%0d: got %h want %h", c, {a_rv[2], a_rd[2], b_rv[2], b_rd[2]}, e);
      end
      @(negedge clk);
    end
    idle();
  endtask

  initial begin
    arst = 1'b1;
    idle();
    test_reset();
    test_basic();
    test_partial();
    test_reset_midflight();
    test_collision();
    test_rdw();
    test_latency();
    test_random();
    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
